baccarat_dealer: RTL and testbench
==================================

# baccarat_dealer

Sequential dealer for the baccarat datapath, and the card-producing end of the hand-scoring interface. It draws 4-bit card codes from an internal free-running deck counter and deals them into player and dealer hand registers in baccarat order on each step request. It scores both hands internally with the same rule the scoring block applies, decides whether third cards are drawn, and flags the winner. The outputs feed the scoring block and the 7-segment display logic directly.

## Interface

**Parameters:** none.

**Ports:**
- slow_clock  input  1  sole clock; all state updates on the rising edge.
- resetb  input  1  asynchronous active-low reset.
- step  input  1  deal request; each high cycle in a deal state deals one card. Must be a single-cycle pulse, edge-detected upstream.
- pcard1, pcard2, pcard3  output  4  player cards. 0 = not dealt, 1 = Ace, 2–10 = pips, 11–13 = J/Q/K.
- dcard1, dcard2, dcard3  output  4  dealer cards, same encoding.
- pscore, dscore  output  4  current hand totals, 0–9.
- done  output  1  hand complete.
- player_win, dealer_win  output  1  result, valid only when done=1. Both high means a tie.

## Operation

**Card value and score**
- Card value: codes 1–9 are worth their code; codes 0 and 10–13 are worth 0.
- Hand score = (sum of the three card values) mod 10.
- The sum needs at least 5 bits (max 27); reduce it with mod 10.
- pscore and dscore are registered and update the cycle after any card load.

**Deck**
- Internal 4-bit counter, reset to 1.
- Increments every cycle, unconditionally, and wraps 13 → 1.
- A card dealt in cycle n takes the deck value present in cycle n.

**States:** P1, D1, P2, D2, EVAL, P3, D3, DONE. Reset state is P1.
- P1 / D1 / P2 / D2: when step=1, load the deck value into pcard1 / dcard1 / pcard2 / dcard2 respectively and advance. When step=0, hold.
- D2 → EVAL unconditionally. EVAL lasts one cycle, ignores step, and decides using the registered pscore and dscore:
  - **Natural:** pscore ≥ 8 or dscore ≥ 8 → DONE.
  - **Player draws:** pscore ≤ 5 → P3.
  - **Player stands:** pscore 6–7 and dscore ≤ 5 → D3. Otherwise → DONE.
- P3: when step=1, load pcard3 and go to D3 or DONE using the dealer rule below. Let v = value of the card being loaded (combinational from the deck). The dealer draws when:
  - dscore ≤ 2;
  - dscore = 3 and v ≠ 8;
  - dscore = 4 and v is 2–7;
  - dscore = 5 and v is 4–7;
  - dscore = 6 and v is 6–7.
  - dscore = 7: the dealer never draws.
- D3: when step=1, load dcard3 and go to DONE.
- DONE:
  - Assert done.
  - player_win = (pscore ≥ dscore); dealer_win = (dscore ≥ pscore).
  - Ignore step. Hold until reset.

**Reset**
- Asynchronous, at any time including mid-hand. All outputs go to 0, the state goes to P1, and the deck goes to 1.
- No partial hand survives reset.

## Timing
- All outputs are registered. Reset value of every output is 0.
- A card register updates on the edge that samples step=1, so it is visible the following cycle.
- Scores lag card loads by one cycle.
- EVAL occupies exactly the cycle after D2's load; pscore and dscore are valid then.
- done, player_win and dealer_win assert on the same edge that enters DONE, and stay stable until reset.
- step pulses in EVAL or DONE are lost. The bench must not count them as deals.
- Minimum hand length: 5 cycles for a natural, 7 cycles with both third cards.

## Test plan
1. **Reset values.** Hold resetb=0, then release. Require all outputs 0 and deck=1. Deal with step at deck values 1, 2, 3, 4 → pcard1=1, dcard1=2, pcard2=3, dcard2=4.
2. **Natural.** Deal P1=4, D1=1, P2=5, D2=2 → pscore=9, dscore=3. Then done=1, player_win=1, dealer_win=0, and pcard3=dcard3=0.
3. **Player draws, dealer stands.** Deal P1=1, D1=3, P2=2, D2=4 (pscore=3, dscore=7). Then P3=9 → pscore=2, done=1, dealer_win=1, dcard3=0.
4. **Dealer rule on 3.** Deal P1=10, D1=1, P2=12, D2=2 (pscore=0, dscore=3). P3=8 → done without dcard3. Repeat with P3=7 → dealer draws dcard3.
5. **Player stands, dealer draws.** Deal P1=3, D1=13, P2=4, D2=11 (pscore=7, dscore=0). Then D3=7 → dscore=7, tie: player_win=dealer_win=1.
6. **Mid-hand reset and ignored step.** Assert resetb=0 asynchronously while in P3 → all outputs 0 within the same cycle. Pulse step during EVAL → no card register changes.

Source files
------------

// File: rtl/baccarat_dealer.sv
// Baccarat dealer: deals cards from a free-running deck into player/dealer hands,
// scores both hands, applies the third-card rules and flags the winner.
module baccarat_dealer (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       step,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  typedef enum logic [2:0] {P1, D1, P2, D2, EVAL, P3, D3, DONE} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_deck;
  logic       w_ld_p1, w_ld_p2, w_ld_p3, w_ld_d1, w_ld_d2, w_ld_d3;
  logic       w_dealer_draws;
  logic [3:0] w_v;
  logic [3:0] w_p1, w_p2, w_p3, w_d1, w_d2, w_d3;
  logic [3:0] w_pscore, w_dscore;

  function automatic logic [3:0] card_val(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] s;
    logic [4:0] m;
    s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
    m = s;
    if (s >= 5'd20)      m = s - 5'd20;
    else if (s >= 5'd10) m = s - 5'd10;
    return m[3:0];
  endfunction

  // Value of the card that would be dealt this cycle drives the dealer's P3 decision.
  assign w_v = card_val(r_deck);

  always_comb begin
    case (dscore)
      4'd0, 4'd1, 4'd2: w_dealer_draws = 1'b1;
      4'd3:             w_dealer_draws = (w_v != 4'd8);
      4'd4:             w_dealer_draws = (w_v >= 4'd2 && w_v <= 4'd7);
      4'd5:             w_dealer_draws = (w_v >= 4'd4 && w_v <= 4'd7);
      4'd6:             w_dealer_draws = (w_v >= 4'd6 && w_v <= 4'd7);
      default:          w_dealer_draws = 1'b0;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_ld_p1 = 1'b0;
    w_ld_p2 = 1'b0;
    w_ld_p3 = 1'b0;
    w_ld_d1 = 1'b0;
    w_ld_d2 = 1'b0;
    w_ld_d3 = 1'b0;
    case (r_state)
      P1:   if (step) begin w_ld_p1 = 1'b1; w_next = D1;   end
      D1:   if (step) begin w_ld_d1 = 1'b1; w_next = P2;   end
      P2:   if (step) begin w_ld_p2 = 1'b1; w_next = D2;   end
      D2:   if (step) begin w_ld_d2 = 1'b1; w_next = EVAL; end
      EVAL: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) w_next = DONE;
        else if (pscore <= 4'd5)              w_next = P3;
        else if (dscore <= 4'd5)              w_next = D3;
        else                                  w_next = DONE;
      end
      P3:   if (step) begin
        w_ld_p3 = 1'b1;
        w_next  = w_dealer_draws ? D3 : DONE;
      end
      D3:   if (step) begin w_ld_d3 = 1'b1; w_next = DONE; end
      default: w_next = DONE;
    endcase
  end

  assign w_p1 = w_ld_p1 ? r_deck : pcard1;
  assign w_p2 = w_ld_p2 ? r_deck : pcard2;
  assign w_p3 = w_ld_p3 ? r_deck : pcard3;
  assign w_d1 = w_ld_d1 ? r_deck : dcard1;
  assign w_d2 = w_ld_d2 ? r_deck : dcard2;
  assign w_d3 = w_ld_d3 ? r_deck : dcard3;

  // Scores are registered from the post-load hand so EVAL sees the complete two-card totals.
  assign w_pscore = hand_score(w_p1, w_p2, w_p3);
  assign w_dscore = hand_score(w_d1, w_d2, w_d3);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state    <= P1;
      r_deck     <= 4'd1;
      pcard1     <= 4'd0;
      pcard2     <= 4'd0;
      pcard3     <= 4'd0;
      dcard1     <= 4'd0;
      dcard2     <= 4'd0;
      dcard3     <= 4'd0;
      pscore     <= 4'd0;
      dscore     <= 4'd0;
      done       <= 1'b0;
      player_win <= 1'b0;
      dealer_win <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_deck     <= (r_deck == 4'd13) ? 4'd1 : r_deck + 4'd1;
      pcard1     <= w_p1;
      pcard2     <= w_p2;
      pcard3     <= w_p3;
      dcard1     <= w_d1;
      dcard2     <= w_d2;
      dcard3     <= w_d3;
      pscore     <= w_pscore;
      dscore     <= w_dscore;
      done       <= (w_next == DONE);
      player_win <= (w_next == DONE) && (w_pscore >= w_dscore);
      dealer_win <= (w_next == DONE) && (w_dscore >= w_pscore);
    end
  end

endmodule

// File: tb/tb_baccarat_dealer.sv
// Directed bench for baccarat_dealer: deals hands at chosen deck values and checks results.
module tb_baccarat_dealer;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic       step       = 1'b0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic       done, player_win, dealer_win;
  logic [3:0] md;
  int         n_checks = 0;
  int         n_err    = 0;

  baccarat_dealer dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .step       (step),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .done       (done),
    .player_win (player_win),
    .dealer_win (dealer_win)
  );

  always #5 slow_clock = ~slow_clock;

  // Reference deck: 1 after reset, +1 per cycle, 13 wraps to 1.
  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) md <= 4'd1;
    else         md <= (md == 4'd13) ? 4'd1 : md + 4'd1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pcard1"}, {4'd0, pcard1}, 8'd0);
    chk({tag, "_pcard2"}, {4'd0, pcard2}, 8'd0);
    chk({tag, "_pcard3"}, {4'd0, pcard3}, 8'd0);
    chk({tag, "_dcard1"}, {4'd0, dcard1}, 8'd0);
    chk({tag, "_dcard2"}, {4'd0, dcard2}, 8'd0);
    chk({tag, "_dcard3"}, {4'd0, dcard3}, 8'd0);
    chk({tag, "_pscore"}, {4'd0, pscore}, 8'd0);
    chk({tag, "_dscore"}, {4'd0, dscore}, 8'd0);
    chk({tag, "_flags"}, {5'd0, done, player_win, dealer_win}, 8'd0);
  endtask

  task automatic do_reset();
    step   = 1'b0;
    resetb = 1'b0;
    repeat (2) @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  // Waits (bounded) until the deck shows v, then pulses step for that one cycle.
  task automatic deal(input logic [3:0] v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (md == v) begin
        step = 1'b1;
        @(negedge slow_clock);
        step  = 1'b0;
        found = 1'b1;
      end else begin
        @(negedge slow_clock);
      end
    end
    n_checks++;
    assert (found) else begin
      n_err++;
      $error("FAIL deal_timeout: observed=deck never %0d expected=deck %0d", v, v);
    end
  endtask

  task automatic chk_result(input string tag, input logic pw, input logic dw);
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_pwin"}, {7'd0, player_win}, {7'd0, pw});
    chk({tag, "_dwin"}, {7'd0, dealer_win}, {7'd0, dw});
  endtask

  initial begin
    // 1: reset values and in-order dealing from deck 1..4
    step   = 1'b0;
    resetb = 1'b0;
    repeat (2) @(negedge slow_clock);
    chk_zero("rst");
    resetb = 1'b1;
    deal(4'd1); deal(4'd2); deal(4'd3); deal(4'd4);
    chk("t1_pcard1", {4'd0, pcard1}, 8'd1);
    chk("t1_dcard1", {4'd0, dcard1}, 8'd2);
    chk("t1_pcard2", {4'd0, pcard2}, 8'd3);
    chk("t1_dcard2", {4'd0, dcard2}, 8'd4);

    // 2: player natural 9 vs 3
    do_reset();
    deal(4'd4); deal(4'd1); deal(4'd5); deal(4'd2);
    chk("t2_eval_done", {7'd0, done}, 8'd0);
    @(negedge slow_clock);
    chk_result("t2", 1'b1, 1'b0);
    chk("t2_pscore", {4'd0, pscore}, 8'd9);
    chk("t2_dscore", {4'd0, dscore}, 8'd3);
    chk("t2_pcard3", {4'd0, pcard3}, 8'd0);
    chk("t2_dcard3", {4'd0, dcard3}, 8'd0);
    step = 1'b1;
    @(negedge slow_clock);
    step = 1'b0;
    @(negedge slow_clock);
    chk("t2_ign_pcard3", {4'd0, pcard3}, 8'd0);
    chk("t2_ign_dcard3", {4'd0, dcard3}, 8'd0);
    chk("t2_ign_done", {7'd0, done}, 8'd1);

    // 3: player draws 9, dealer stands on 7
    do_reset();
    deal(4'd1); deal(4'd3); deal(4'd2); deal(4'd4);
    @(negedge slow_clock);
    deal(4'd9);
    chk_result("t3", 1'b0, 1'b1);
    chk("t3_pcard3", {4'd0, pcard3}, 8'd9);
    @(negedge slow_clock);
    chk("t3_pscore", {4'd0, pscore}, 8'd2);
    chk("t3_dscore", {4'd0, dscore}, 8'd7);
    chk("t3_dcard3", {4'd0, dcard3}, 8'd0);

    // 4a: dealer on 3 stands when player's third card is 8
    do_reset();
    deal(4'd10); deal(4'd1); deal(4'd12); deal(4'd2);
    @(negedge slow_clock);
    deal(4'd8);
    chk_result("t4a", 1'b1, 1'b0);
    @(negedge slow_clock);
    chk("t4a_dcard3", {4'd0, dcard3}, 8'd0);
    chk("t4a_pscore", {4'd0, pscore}, 8'd8);

    // 4b: dealer on 3 draws when player's third card is 7
    do_reset();
    deal(4'd10); deal(4'd1); deal(4'd12); deal(4'd2);
    @(negedge slow_clock);
    deal(4'd7);
    chk("t4b_not_done", {7'd0, done}, 8'd0);
    deal(4'd5);
    chk_result("t4b", 1'b0, 1'b1);
    chk("t4b_dcard3", {4'd0, dcard3}, 8'd5);
    @(negedge slow_clock);
    chk("t4b_dscore", {4'd0, dscore}, 8'd8);

    // 5: player stands on 7, dealer draws from 0 to a tie
    do_reset();
    deal(4'd3); deal(4'd13); deal(4'd4); deal(4'd11);
    @(negedge slow_clock);
    deal(4'd7);
    chk_result("t5", 1'b1, 1'b1);
    chk("t5_pcard3", {4'd0, pcard3}, 8'd0);
    @(negedge slow_clock);
    chk("t5_dscore", {4'd0, dscore}, 8'd7);
    chk("t5_pscore", {4'd0, pscore}, 8'd7);

    // 6: step in EVAL is lost, then asynchronous reset while in P3
    do_reset();
    deal(4'd1); deal(4'd2); deal(4'd3); deal(4'd4);
    step = 1'b1;
    @(negedge slow_clock);
    step = 1'b0;
    chk("t6_pcard1", {4'd0, pcard1}, 8'd1);
    chk("t6_dcard2", {4'd0, dcard2}, 8'd4);
    chk("t6_pcard3", {4'd0, pcard3}, 8'd0);
    chk("t6_done", {7'd0, done}, 8'd0);
    #2 resetb = 1'b0;
    #1 chk_zero("t6_async");
    @(negedge slow_clock);
    resetb = 1'b1;
    deal(4'd1);
    chk("t6_after_pcard1", {4'd0, pcard1}, 8'd1);
    chk("t6_after_dcard1", {4'd0, dcard1}, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
